// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and PC constants for the instruction fetch unit.
package ifu_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} ifu_state_e;
   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] PC_RESET = 32'd100;
   localparam logic [PC_W-1:0] PC_STEP = 32'd4;
   localparam logic [PC_W-1:0] PC_LIMIT = 32'd255;
endpackage

// File: rtl/ifu_out_reg.sv
// ifu_out_reg: valid/ready output register holding the fetched instruction and its address.
module ifu_out_reg
   import ifu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            flush,
   input  logic            ready,
   input  logic [PC_W-1:0] data_in,
   input  logic [PC_W-1:0] pc_in,
   output logic [PC_W-1:0] inst_out,
   output logic [PC_W-1:0] pc_out,
   output logic            inst_valid
);
   logic [PC_W-1:0] inst_q, inst_d, pc_q, pc_d;
   logic            valid_q, valid_d;
   // A handshake without a new load drains the register.
   always_comb begin
      valid_d = flush ? 1'b0 : load ? 1'b1 : (valid_q && ready) ? 1'b0 : valid_q;
      inst_d  = load ? data_in : inst_q;
      pc_d    = load ? pc_in : pc_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_q  <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end
   assign inst_out   = inst_q;
   assign pc_out     = pc_q;
   assign inst_valid = valid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencer feeding decode over valid/ready with start/halt control.
// IFU_LIMIT_HALT_EN: halt instead of fetching past PC_LIMIT.
module instruction_fetch_unit
   import ifu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [PC_W-1:0] imem_data,
   output logic [PC_W-1:0] inst_out,
   output logic [PC_W-1:0] pc_out,
   output logic            inst_valid,
   input  logic            inst_ready,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_target,
   output logic            halted,
   output logic            busy
);
   ifu_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            load, flush, can_load, over;
   assign can_load = !inst_valid || inst_ready;
`ifdef IFU_LIMIT_HALT_EN
   assign over   = pc_q > PC_LIMIT;
   assign halted = state_q == HALT;
`else
   assign over   = 1'b0;
   assign halted = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            pc_d    = redirect ? redirect_target : pc_q;
            state_d = start ? FETCH : IDLE;
         end
         FETCH, STALL, HALT: begin
            // Redirect wins over any load; a same-cycle handshake is simply dropped by the flush.
            if (redirect) begin
               pc_d    = redirect_target;
               flush   = 1'b1;
               state_d = FETCH;
            end else if (state_q != HALT) begin
               if (!can_load) begin
                  state_d = STALL;
               end else if (over) begin
                  state_d = HALT;
               end else begin
                  load    = 1'b1;
                  pc_d    = pc_q + PC_STEP;
                  state_d = FETCH;
               end
            end
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= PC_RESET;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end
   ifu_out_reg u_out (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .flush      (flush),
      .ready      (inst_ready),
      .data_in    (imem_data),
      .pc_in      (pc_q),
      .inst_out   (inst_out),
      .pc_out     (pc_out),
      .inst_valid (inst_valid)
   );
   assign imem_addr = pc_q;
   assign busy      = state_q == FETCH || state_q == STALL;
endmodule
